// File: rtl/btod_sequencer.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | btod_sequencer: buffers commands, does the startDone handshake, then issues |
// | them one at a time over btod req/ack and returns the ack data.  Rev 1.0     |
// +-----------------------------------------------------------------------------+
module btod_sequencer #(
  parameter int DEPTH   = 4,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              cmd_vld,
  output logic              cmd_rdy,
  input  logic [DATA_W-1:0] cmd_data,
  output logic              start_notify,
  input  logic              start_ack,
  output logic              btod_req,
  output logic [DATA_W-1:0] btod_data,
  input  logic              btod_ack,
  input  logic [DATA_W-1:0] btod_ack_data,
  output logic              rsp_vld,
  input  logic              rsp_rdy,
  output logic [DATA_W-1:0] rsp_data,
  output logic              err_timeout,
  input  logic              clr_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [TW-1:0] TMAX     = TW'(TIMEOUT);

  typedef enum logic [2:0] {IDLE, START, READY, REQ, RSP} state_t;

  state_t            state;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [CW-1:0]     count;
  logic [TW-1:0]     timer;
  logic              not_empty;
  logic              push;
  logic              pop;

  assign not_empty = (count != '0);
  assign cmd_rdy   = (count != FULL_CNT);
  assign push      = cmd_vld && cmd_rdy;
  assign pop       = (state == READY) && enable && not_empty;

  // Storage carries no reset; the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= cmd_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      start_notify <= 1'b0;
      btod_req     <= 1'b0;
      btod_data    <= '0;
      rsp_vld      <= 1'b0;
      rsp_data     <= '0;
      err_timeout  <= 1'b0;
      timer        <= '0;
    end else begin
      // Clear first so a timeout in the same cycle overrides it.
      if (clr_err) err_timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (enable) begin
            start_notify <= 1'b1;
            state        <= START;
          end
        end
        START: begin
          if (start_ack) begin
            start_notify <= 1'b0;
            state        <= READY;
          end
        end
        READY: begin
          if (!enable) begin
            state <= IDLE;
          end else if (not_empty) begin
            btod_data <= mem[rd_ptr];
            btod_req  <= 1'b1;
            timer     <= '0;
            state     <= REQ;
          end
        end
        REQ: begin
          if (btod_ack) begin
            btod_req <= 1'b0;
            rsp_data <= btod_ack_data;
            rsp_vld  <= 1'b1;
            state    <= RSP;
          end else if (timer == TMAX) begin
            btod_req    <= 1'b0;
            err_timeout <= 1'b1;
            state       <= READY;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        RSP: begin
          if (rsp_rdy) begin
            rsp_vld <= 1'b0;
            state   <= READY;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_btod_sequencer.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | tb_btod_sequencer: directed self-checking bench for btod_sequencer. Rev 1.0 |
// +-----------------------------------------------------------------------------+
module tb_btod_sequencer;

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic        cmd_vld;
  logic        cmd_rdy;
  logic [31:0] cmd_data;
  logic        start_notify;
  logic        start_ack;
  logic        btod_req;
  logic [31:0] btod_data;
  logic        btod_ack;
  logic [31:0] btod_ack_data;
  logic        rsp_vld;
  logic        rsp_rdy;
  logic [31:0] rsp_data;
  logic        err_timeout;
  logic        clr_err;

  int tests = 0;
  int fails = 0;

  btod_sequencer #(.DEPTH(4), .DATA_W(32), .TIMEOUT(255)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .cmd_vld(cmd_vld), .cmd_rdy(cmd_rdy), .cmd_data(cmd_data),
    .start_notify(start_notify), .start_ack(start_ack),
    .btod_req(btod_req), .btod_data(btod_data),
    .btod_ack(btod_ack), .btod_ack_data(btod_ack_data),
    .rsp_vld(rsp_vld), .rsp_rdy(rsp_rdy), .rsp_data(rsp_data),
    .err_timeout(err_timeout), .clr_err(clr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_req();
    int n = 0;
    while (btod_req !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    chk("wait_req", {31'd0, btod_req}, 32'd1);
  endtask

  task automatic push1(input logic [31:0] d);
    cmd_vld  = 1'b1;
    cmd_data = d;
    tick();
    cmd_vld  = 1'b0;
  endtask

  initial begin
    int hi;
    rst_n = 1'b0; enable = 1'b0; cmd_vld = 1'b0; cmd_data = '0;
    start_ack = 1'b0; btod_ack = 1'b0; btod_ack_data = '0;
    rsp_rdy = 1'b0; clr_err = 1'b0;
    tick(); tick();
    chk("rst_notify", {31'd0, start_notify}, 32'd0);
    chk("rst_req",    {31'd0, btod_req},     32'd0);
    chk("rst_rspvld", {31'd0, rsp_vld},      32'd0);
    chk("rst_err",    {31'd0, err_timeout},  32'd0);
    chk("rst_cmdrdy", {31'd0, cmd_rdy},      32'd1);
    chk("rst_bdata",  btod_data,             32'd0);
    chk("rst_rdata",  rsp_data,              32'd0);

    // Start handshake: start_ack seen on the 4th edge -> notify high 3 cycles.
    rst_n = 1'b1; enable = 1'b1;
    tick(); chk("notify_c1", {31'd0, start_notify}, 32'd1);
    tick(); chk("notify_c2", {31'd0, start_notify}, 32'd1);
    tick(); chk("notify_c3", {31'd0, start_notify}, 32'd1);
    start_ack = 1'b1;
    tick(); start_ack = 1'b0;
    chk("notify_drop", {31'd0, start_notify}, 32'd0);

    push1(32'hA5);
    chk("req_latency0", {31'd0, btod_req}, 32'd0);
    tick();
    chk("req_rise", {31'd0, btod_req}, 32'd1);
    chk("req_data", btod_data, 32'hA5);
    btod_ack = 1'b1; btod_ack_data = 32'h5A;
    tick(); btod_ack = 1'b0;
    chk("ack_req_low", {31'd0, btod_req}, 32'd0);
    chk("ack_rspvld",  {31'd0, rsp_vld},  32'd1);
    chk("ack_rspdata", rsp_data, 32'h5A);
    rsp_rdy = 1'b1; tick(); rsp_rdy = 1'b0;
    chk("rsp_done", {31'd0, rsp_vld}, 32'd0);

    // Five back-to-back pushes with acks withheld; command 1 is popped at once.
    cmd_vld = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      cmd_data = k;
      tick();
      if (k == 4) chk("rdy_after4", {31'd0, cmd_rdy}, 32'd1);
    end
    chk("full_rdy_low", {31'd0, cmd_rdy}, 32'd0);
    cmd_data = 32'd6;
    tick(); cmd_vld = 1'b0;
    chk("full_still_low", {31'd0, cmd_rdy}, 32'd0);
    chk("full_head", btod_data, 32'd1);
    for (int k = 1; k <= 5; k++) begin
      wait_req();
      chk("order_data", btod_data, k);
      btod_ack = 1'b1; btod_ack_data = 32'h100 + k;
      tick(); btod_ack = 1'b0;
      chk("order_rsp", rsp_data, 32'h100 + k);
      rsp_rdy = 1'b1; tick(); rsp_rdy = 1'b0;
    end
    repeat (4) tick();
    chk("no_bypass", {31'd0, btod_req}, 32'd0);

    // Timeout: request held exactly 256 cycles, then next command proceeds.
    push1(32'h77);
    push1(32'h88);
    wait_req();
    chk("to_data", btod_data, 32'h77);
    hi = 1;
    for (int i = 0; i < 400 && btod_req; i++) begin
      tick();
      if (btod_req) hi++;
    end
    chk("to_req_cycles", hi, 32'd256);
    chk("to_err_set", {31'd0, err_timeout}, 32'd1);
    wait_req();
    chk("to_next_data", btod_data, 32'h88);
    chk("to_err_sticky", {31'd0, err_timeout}, 32'd1);
    clr_err = 1'b1; tick(); clr_err = 1'b0;
    chk("clr_err", {31'd0, err_timeout}, 32'd0);
    btod_ack = 1'b1; btod_ack_data = 32'h1234;
    tick(); btod_ack = 1'b0;
    chk("to_next_rsp", rsp_data, 32'h1234);
    rsp_rdy = 1'b1; tick(); rsp_rdy = 1'b0;

    // Ack on the last permitted cycle wins over the timeout.
    push1(32'h99);
    wait_req();
    repeat (255) tick();
    chk("edge_req_high", {31'd0, btod_req}, 32'd1);
    btod_ack = 1'b1; btod_ack_data = 32'hBEEF;
    tick(); btod_ack = 1'b0;
    chk("edge_rspvld", {31'd0, rsp_vld},     32'd1);
    chk("edge_req_low", {31'd0, btod_req},   32'd0);
    chk("edge_no_err", {31'd0, err_timeout}, 32'd0);
    chk("edge_rspdata", rsp_data, 32'hBEEF);

    // Response backpressure with a command waiting.
    push1(32'hC1);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("hold_flags", {30'd0, rsp_vld, btod_req}, 32'd2);
      chk("hold_data", rsp_data, 32'hBEEF);
    end
    rsp_rdy = 1'b1; tick(); rsp_rdy = 1'b0;
    wait_req();
    chk("c1_data", btod_data, 32'hC1);

    // Drop enable mid-REQ: transaction completes, then IDLE with FIFO kept.
    push1(32'hD1);
    enable = 1'b0;
    btod_ack = 1'b1; btod_ack_data = 32'hC2;
    tick(); btod_ack = 1'b0;
    chk("dis_rspvld", {31'd0, rsp_vld}, 32'd1);
    chk("dis_rspdata", rsp_data, 32'hC2);
    rsp_rdy = 1'b1; tick(); rsp_rdy = 1'b0;
    repeat (5) tick();
    chk("dis_no_req", {31'd0, btod_req}, 32'd0);
    chk("dis_no_notify", {31'd0, start_notify}, 32'd0);
    enable = 1'b1;
    tick();
    chk("reen_notify", {31'd0, start_notify}, 32'd1);
    chk("reen_no_req", {31'd0, btod_req}, 32'd0);
    start_ack = 1'b1; tick(); start_ack = 1'b0;
    chk("reen_notify_drop", {31'd0, start_notify}, 32'd0);
    wait_req();
    chk("kept_data", btod_data, 32'hD1);

    // Asynchronous reset in REQ with one more command buffered.
    push1(32'hE1);
    #2; rst_n = 1'b0; #1;
    chk("arst_req",    {31'd0, btod_req}, 32'd0);
    chk("arst_bdata",  btod_data, 32'd0);
    chk("arst_cmdrdy", {31'd0, cmd_rdy}, 32'd1);
    tick(); rst_n = 1'b1;
    tick();
    chk("arst_notify", {31'd0, start_notify}, 32'd1);
    start_ack = 1'b1; tick(); start_ack = 1'b0;
    repeat (6) tick();
    chk("arst_flushed", {31'd0, btod_req}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/btod_sequencer.md
# btod_sequencer

Upstream command stage for blockB. It accepts commands on a ready/valid input and buffers them in a small FIFO. Before any traffic it performs the startDone notify/ack handshake. It then issues each command to blockB over the btod req/ack channel, one at a time, and returns blockB's acknowledge data on a ready/valid response output. A per-request timeout raises a sticky error.

## Interface
Parameters:
- DEPTH, 4, command FIFO entries; power of 2, ≥2
- DATA_W, 32, command and response payload width
- TIMEOUT, 255, cycles to wait for btod_ack before abandoning a request; ≥1

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- enable  in  1  level; permits leaving IDLE
- cmd_vld  in  1  command valid
- cmd_rdy  out  1  command ready; equals (fifo count != DEPTH)
- cmd_data  in  DATA_W  command payload
- start_notify  out  1  startDone notify to blockB
- start_ack  in  1  startDone acknowledge from blockB
- btod_req  out  1  request to blockB
- btod_data  out  DATA_W  request payload; stable while btod_req=1
- btod_ack  in  1  one-cycle acknowledge from blockB
- btod_ack_data  in  DATA_W  response payload; valid when btod_ack=1
- rsp_vld  out  1  response valid
- rsp_rdy  in  1  response ready
- rsp_data  out  DATA_W  response payload
- err_timeout  out  1  sticky timeout flag
- clr_err  in  1  clears err_timeout

## Operation
- Reset values:
  - start_notify, btod_req, rsp_vld, err_timeout: 0
  - btod_data, rsp_data: 0
  - cmd_rdy: 1, because the FIFO is empty
  - state: IDLE; FIFO pointers and count: 0
- FIFO:
  - push when cmd_vld && cmd_rdy; pop when READY has a command and FIFO is non-empty
  - pointers wrap modulo DEPTH; count is clog2(DEPTH+1) bits
  - simultaneous push and pop leaves count unchanged
  - when full, cmd_rdy=0 and there is no bypass
- State machine:
  - IDLE: if enable=1 → START.
  - START: start_notify=1 until start_ack=1 is sampled; then start_notify←0 and → READY.
  - READY: if enable=0 → IDLE; else if FIFO non-empty → pop, btod_data←head, btod_req←1, timer←0, → REQ. enable is checked before the FIFO.
  - REQ:
    - btod_ack=1 → btod_req←0, rsp_data←btod_ack_data, rsp_vld←1, → RSP.
    - btod_ack=0 and timer==TIMEOUT → btod_req←0, err_timeout←1, command discarded, → READY.
    - otherwise timer+1. Timer is clog2(TIMEOUT+1) bits and never wraps.
  - RSP: when rsp_rdy=1 → rsp_vld←0, → READY.
- Only one request is outstanding at a time. A btod_ack outside REQ is ignored.
- enable deasserted mid-transaction: the current REQ/RSP completes first, then READY→IDLE. FIFO contents are retained. Re-entering requires a new start handshake.
- err_timeout:
  - set has priority over clr_err in the same cycle
  - while set, it does not block further requests
- Reset asserted mid-operation:
  - all outputs drop immediately, asynchronously
  - FIFO is flushed
  - no handshake is completed

## Timing
- Command pushed at edge N, FIFO previously empty, state READY: btod_req=1 visible in cycle N+1, i.e. after edge N+1.
- btod_ack sampled high at edge M: btod_req=0 and rsp_vld=1 after edge M.
- rsp_rdy sampled at edge K: rsp_vld=0 after K. The next btod_req can rise after K+1, so btod_req is low for at least 2 cycles between requests.
- btod_ack on the same edge that timer reaches TIMEOUT: ack wins and no error is set.
- Timeout: btod_req is held for exactly TIMEOUT+1 cycles, then dropped.
- start_ack seen at edge S: start_notify=0 after S. The first btod_req can rise after S+1.

## Test plan
- Reset then enable=1, start_ack after 3 cycles, push cmd 0xA5 → start_notify high for 3 cycles; btod_req high with btod_data=0xA5; ack with btod_ack_data=0x5A → rsp_data=0x5A, rsp_vld=1.
- Push 5 commands back-to-back with btod_ack withheld (DEPTH=4) → cmd_rdy low after the 4th push into the FIFO (one command already popped); commands are delivered in order once acks resume.
- Never ack (TIMEOUT=255) → btod_req high 256 cycles then low, err_timeout=1, next command issued; clr_err → 0.
- Ack on exactly the 256th request cycle → rsp_vld=1, err_timeout stays 0.
- Hold rsp_rdy=0 for 10 cycles → rsp_vld and rsp_data stable, btod_req stays 0 throughout.
- Drop enable in REQ → response completes, state returns to IDLE, FIFO kept. Re-enable → start_notify pulses before the next btod_req. Assert rst_n=0 mid-REQ → btod_req=0 immediately, FIFO empty afterwards.
